// File: rtl/hyperbus_target.sv
// ---------------------------------------------------------------------------
// hyperbus_target
// Simplified HyperBus target: a 2^ADDR_W x 16-bit memory array plus a
// read-only ID0 register and a writable CR0 register. One DDR word (two
// bytes) is transferred per clk cycle. A transaction is a three-word
// command/address phase, a fixed initial latency, then a data burst that
// runs until csn is released.
//
// Ports
//   clk      : single clock
//   rst      : asynchronous active-high reset
//   csn      : chip select, active low
//   dq_in    : received word, [15:8] is the first (rising-edge) byte
//   rwds_in  : write byte masks, [1] masks dq_in[15:8], [0] masks dq_in[7:0]
//   dq_out   : read data word
//   dq_oe    : dq output enable
//   rwds_out : read strobe
//   rwds_oe  : rwds output enable
//   cr0      : current CR0 contents
//   busy     : high whenever the target is not idle
// ---------------------------------------------------------------------------
module hyperbus_target #(
  parameter int          ADDR_W  = 8,
  parameter int          LAT_CYC = 6,
  parameter logic [15:0] ID0_VAL = 16'h0C81,
  parameter logic [15:0] CR0_RST = 16'h8F1F
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        csn,
  input  logic [15:0] dq_in,
  input  logic [1:0]  rwds_in,
  output logic [15:0] dq_out,
  output logic        dq_oe,
  output logic        rwds_out,
  output logic        rwds_oe,
  output logic [15:0] cr0,
  output logic        busy
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int LAT_W = (LAT_CYC > 1) ? $clog2(LAT_CYC) : 1;
  localparam logic [LAT_W-1:0]  LAT_LOAD  = LAT_W'(LAT_CYC - 1);
  localparam logic [ADDR_W-1:0] WRAP_MASK = ADDR_W'(15);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CA    = 3'd1;
  localparam logic [2:0] S_LAT   = 3'd2;
  localparam logic [2:0] S_WDATA = 3'd3;
  localparam logic [2:0] S_RDATA = 3'd4;
  localparam logic [2:0] S_REGW  = 3'd5;
  localparam logic [2:0] S_ABORT = 3'd6;

  logic [2:0]        r_state;
  logic [47:0]       r_ca;
  logic [1:0]        r_ca_cnt;
  logic [LAT_W-1:0]  r_lat_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [15:0]       r_dq_out;
  logic              r_dq_oe;
  logic              r_rwds_out;
  logic              r_rwds_oe;
  logic [15:0]       r_cr0;
  logic              r_busy;

  logic [15:0]       r_mem [DEPTH];

  logic [47:0]       w_ca_full;
  logic [31:0]       w_start_full;
  logic [ADDR_W-1:0] w_start_addr;
  logic [ADDR_W-1:0] w_addr_inc;
  logic [ADDR_W-1:0] w_addr_next;
  logic [15:0]       w_rd_word;
  logic [1:0]        w_we;
  logic              w_unused;

  // Word 2 is still on dq_in when the command is decoded, so the decode
  // looks at the captured upper words together with the live input.
  assign w_ca_full    = {r_ca[47:16], dq_in};
  assign w_start_full = {w_ca_full[44:16], w_ca_full[2:0]};
  assign w_start_addr = w_start_full[ADDR_W-1:0];

  // Linear bursts roll over the whole array; wrapped bursts only advance
  // the low nibble so they stay inside the aligned 16-word group.
  assign w_addr_inc  = r_addr + ADDR_W'(1);
  assign w_addr_next = r_ca[45] ? w_addr_inc
                                : ((r_addr & ~WRAP_MASK) | (w_addr_inc & WRAP_MASK));

  assign w_rd_word = r_ca[46] ? (r_ca[0] ? r_cr0 : ID0_VAL) : r_mem[r_addr];

  // A word arriving together with csn high belongs to no transaction.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : gen_lane_we
      assign w_we[gi] = (r_state == S_WDATA) && !csn && !rwds_in[gi];
    end
  endgenerate

  // Byte-enabled memory; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (w_we[i]) r_mem[r_addr][i*8 +: 8] <= dq_in[i*8 +: 8];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_ca       <= '0;
      r_ca_cnt   <= '0;
      r_lat_cnt  <= '0;
      r_addr     <= '0;
      r_dq_out   <= '0;
      r_dq_oe    <= 1'b0;
      r_rwds_out <= 1'b0;
      r_rwds_oe  <= 1'b0;
      r_cr0      <= CR0_RST;
      r_busy     <= 1'b0;
    end else begin
      r_dq_oe    <= 1'b0;
      r_rwds_out <= 1'b0;
      r_rwds_oe  <= 1'b0;
      if (csn) begin
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_ca[47:32] <= dq_in;
            r_ca_cnt    <= 2'd1;
            r_state     <= S_CA;
            r_busy      <= 1'b1;
            r_rwds_oe   <= 1'b1;
          end
          S_CA: begin
            if (r_ca_cnt == 2'd1) begin
              r_ca[31:16] <= dq_in;
              r_ca_cnt    <= 2'd2;
              r_rwds_oe   <= 1'b1;
            end else begin
              r_ca[15:0] <= dq_in;
              r_addr     <= w_start_addr;
              r_lat_cnt  <= LAT_LOAD;
              r_state    <= (!w_ca_full[47] && w_ca_full[46]) ? S_REGW : S_LAT;
            end
          end
          S_LAT: begin
            if (r_lat_cnt == '0) begin
              if (r_ca[47]) begin
                // First read word is launched on the last latency edge so
                // it is on the bus for the first data cycle.
                r_state    <= S_RDATA;
                r_dq_out   <= w_rd_word;
                r_dq_oe    <= 1'b1;
                r_rwds_oe  <= 1'b1;
                r_rwds_out <= 1'b1;
                if (!r_ca[46]) r_addr <= w_addr_next;
              end else begin
                r_state <= S_WDATA;
              end
            end else begin
              r_lat_cnt <= r_lat_cnt - LAT_W'(1);
            end
          end
          S_RDATA: begin
            r_dq_out   <= w_rd_word;
            r_dq_oe    <= 1'b1;
            r_rwds_oe  <= 1'b1;
            r_rwds_out <= 1'b1;
            if (!r_ca[46]) r_addr <= w_addr_next;
          end
          S_WDATA: begin
            r_addr <= w_addr_next;
          end
          S_REGW: begin
            if (r_ca[0]) r_cr0 <= dq_in;
            r_state <= S_ABORT;
          end
          default: begin
            // ABORT (and any illegal encoding) waits for csn release.
            r_state <= S_ABORT;
          end
        endcase
      end
    end
  end

  assign dq_out   = r_dq_out;
  assign dq_oe    = r_dq_oe;
  assign rwds_out = r_rwds_out;
  assign rwds_oe  = r_rwds_oe;
  assign cr0      = r_cr0;
  assign busy     = r_busy;

  // Command bits that carry no meaning for this target.
  assign w_unused = &{1'b0, w_ca_full[45], w_ca_full[15:3], r_ca[15:1], w_start_full};

endmodule

// File: doc/hyperbus_target.md
HYPERBUS_TARGET -- requirements
Module: hyperbus_target

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, word-address width; memory depth is 2^ADDR_W 16-bit words.
REQ-002 SHALL have parameter LAT_CYC, default 6, fixed initial latency in clk cycles (min 1).
REQ-003 SHALL have parameter ID0_VAL, default 16'h0C81, read-only ID register value.
REQ-004 SHALL have parameter CR0_RST, default 16'h8F1F, CR0 reset value.
REQ-005 clk  input  1  single clock; one DDR word (two bytes) per cycle.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 csn  input  1  chip select, active low.
REQ-008 dq_in  input  16  received word; [15:8] = first (rising-edge) byte.
REQ-009 rwds_in  input  2  write byte masks; [1] masks dq_in[15:8], [0] masks dq_in[7:0]; 1 = masked.
REQ-010 dq_out  output  16  read data word.
REQ-011 dq_oe  output  1  dq output enable.
REQ-012 rwds_out  output  1  read strobe / latency indication.
REQ-013 rwds_oe  output  1  rwds output enable.
REQ-014 cr0  output  16  current CR0 contents.
REQ-015 busy  output  1  high whenever state is not IDLE.

Function
REQ-016 SHALL implement states IDLE, CA, LAT, WDATA, RDATA, REGW, ABORT; all outputs registered.
REQ-017 IDLE->CA when csn sampled low; the cycle csn first samples low is CA word 0.
REQ-018 CA captures three consecutive words into ca[47:0], word 0 into [47:32], word 2 into [15:0].
REQ-019 Decode: ca[47]=1 read/0 write; ca[46]=1 register space; ca[45]=1 linear burst/0 wrapped; start address = {ca[44:16], ca[2:0]} truncated to ADDR_W.
REQ-020 During CA cycles, rwds_oe SHALL be 1 and rwds_out 0; dq_oe 0.
REQ-021 After word 2: register write -> REGW; all other commands -> LAT for exactly LAT_CYC cycles, then RDATA (read) or WDATA (write).
REQ-022 REGW: word on cycle 3 written to CR0 if ca[0]=1, else ignored; then ABORT until csn high.
REQ-023 RDATA: first word driven on cycle 3+LAT_CYC, one word per cycle, dq_oe=rwds_oe=rwds_out=1 per valid word.
REQ-024 Register read returns ID0_VAL (ca[0]=0) or cr0 (ca[0]=1) on every data cycle; address does not advance.
REQ-025 WDATA: word sampled from cycle 3+LAT_CYC onward; each unmasked byte written; rwds_oe=0, dq_oe=0.
REQ-026 Linear burst address increments by 1 and wraps 2^ADDR_W-1 -> 0.
REQ-027 Wrapped burst increments address[3:0] only, wrapping within the aligned 16-word group; upper bits fixed.
REQ-028 csn sampled high in any state -> IDLE next cycle; dq_oe, rwds_oe, rwds_out 0 that next cycle; a write word coincident with csn high is not written.
REQ-029 csn high during CA aborts with no memory or CR0 change.
REQ-030 Memory contents are not reset; undefined until written.

Reset
REQ-031 rst high SHALL force, asynchronously: state IDLE, dq_out 0, dq_oe 0, rwds_out 0, rwds_oe 0, busy 0, cr0 CR0_RST, ca 0, latency counter 0.
REQ-032 rst mid-burst SHALL abort with no further memory writes; first command after release needs a full CA phase.

Verification
REQ-033 Write addr 0x10, linear, words 0x1234,0xABCD, masks 00 -> read addr 0x10 returns 0x1234,0xABCD on cycles 3+LAT_CYC, 4+LAT_CYC.
REQ-034 Write 0xFFFF to addr 0x20 then 0x0000 with rwds_in=2'b10 -> read returns 0xFF00.
REQ-035 Wrapped read from addr 0x1E, 4 words -> addresses 0x1E,0x1F,0x10,0x11; linear read from 0xFF -> 0xFF,0x00.
REQ-036 Register write CR0=0x8F17 (ca[0]=1) -> cr0=0x8F17; register read ca[0]=0 -> 0x0C81; after rst cr0=0x8F1F.
REQ-037 csn high after 1st of 4 write words -> only first word updated, busy 0 and oe outputs 0 next cycle; csn high on CA word 1 -> no state change.
